bp_nonsynth_io_load_arbiter: RTL

- Two-source arbiter for host-side loader I/O traffic. It merges the NBF loader (source 0) and the CCE MMIO cfg loader (source 1) onto the single host-link memory command/response port.
- It replaces fixed priority muxing with round-robin arbitration and in-order response steering.
- A source-ID FIFO records, in issue order, which loader owns each outstanding command; each returning response is delivered to that owner.
- Nonsynthesizable-bench-side block; sits between the loaders and the host link.

---
 rtl/bp_nonsynth_io_load_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/bp_nonsynth_io_load_arbiter.sv
// Round-robin merge of NBF loader (src 0) and CCE cfg loader (src 1) onto one host-link port; responses steered back in issue order.
// Latency: command and response paths are combinational pass-through; the owner ID is recorded on the command handshake.
// Backpressure: commands stall while max_outstanding_p are in flight; a response waits for its owner's ready.
module bp_nonsynth_io_load_arbiter #(
    parameter int msg_width_p       = 512,
    parameter int max_outstanding_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [2*msg_width_p-1:0] src_cmd_i,
    input  logic [1:0]               src_cmd_v_i,
    output logic [1:0]               src_cmd_yumi_o,
    output logic [msg_width_p-1:0]   src_resp_o,
    output logic [1:0]               src_resp_v_o,
    input  logic [1:0]               src_resp_ready_i,
    output logic [msg_width_p-1:0]   mem_cmd_o,
    output logic                     mem_cmd_v_o,
    input  logic                     mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]   mem_resp_i,
    input  logic                     mem_resp_v_i,
    output logic                     mem_resp_yumi_o,
    output logic                     idle_o,
    output logic                     orphan_resp_o
);

    localparam int ptr_w = $clog2(max_outstanding_p);
    localparam int cnt_w = ptr_w + 1;

    logic                 rr_r;
    logic [ptr_w-1:0]     wr_ptr_r;
    logic [ptr_w-1:0]     rd_ptr_r;
    logic [cnt_w-1:0]     count_r;
    logic                 id_mem_r [max_outstanding_p];
    logic                 orphan_r;

    logic full;
    logic empty;
    logic grant_any;
    logic grant_id;
    logic cmd_hs;
    logic head;
    logic resp_v;
    logic resp_hs;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        full      = (count_r == cnt_w'(max_outstanding_p));
        empty     = (count_r == '0);
        grant_any = |src_cmd_v_i;
        grant_id  = src_cmd_v_i[rr_r] ? rr_r : ~rr_r;
        head      = id_mem_r[rd_ptr_r];
        cmd_hs    = grant_any & ~full & ~reset_i & mem_cmd_ready_i;
        resp_v    = mem_resp_v_i & ~empty & ~reset_i;
        resp_hs   = resp_v & src_resp_ready_i[head];
    end

    assign mem_cmd_v_o     = grant_any & ~full & ~reset_i;
    assign mem_cmd_o       = grant_id ? src_cmd_i[2*msg_width_p-1:msg_width_p]
                                      : src_cmd_i[msg_width_p-1:0];
    assign src_cmd_yumi_o  = cmd_hs ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    assign src_resp_o      = mem_resp_i;
    assign src_resp_v_o    = resp_v ? (head ? 2'b10 : 2'b01) : 2'b00;
    assign mem_resp_yumi_o = resp_hs;

    assign idle_o          = empty;
    assign orphan_resp_o   = orphan_r;

    // ID storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk_i) begin
        if (cmd_hs) begin
            id_mem_r[wr_ptr_r] <= grant_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_r     <= 1'b0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            orphan_r <= 1'b0;
        end else begin
            if (cmd_hs) begin
                wr_ptr_r <= wr_ptr_r + ptr_w'(1);
                rr_r     <= ~grant_id;
            end
            if (resp_hs) begin
                rd_ptr_r <= rd_ptr_r + ptr_w'(1);
            end
            case ({cmd_hs, resp_hs})
                2'b10:   count_r <= count_r + cnt_w'(1);
                2'b01:   count_r <= count_r - cnt_w'(1);
                default: count_r <= count_r;
            endcase
            if (mem_resp_v_i && empty) begin
                orphan_r <= 1'b1;
            end
        end
    end

endmodule
